// File: rtl/ctrl_pkg.sv
// Shared definitions for the EX-stage stall/flush sequencer: mul/div FSM encodings and defaults.
package ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_t;

   localparam int unsigned WIDTH_SOURCE_DEF = 5;
   localparam int unsigned MD_TIMEOUT_DEF   = 40;
   localparam int unsigned CNT_W_DEF        = 32;

endpackage

// File: rtl/ld_use_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction actually reads.
module ld_use_detect #(
   parameter int unsigned W = 5
) (
   input  logic         mem_rd_i,
   input  logic [W-1:0] rd_i,
   input  logic [W-1:0] rs1_i,
   input  logic [W-1:0] rs2_i,
   input  logic         use_rs1_i,
   input  logic         use_rs2_i,
   output logic         hazard_o
);

   logic rd_live;
   logic hit_rs1;
   logic hit_rs2;

   // x0 is hard-wired zero, so a load targeting it never creates a dependency
   assign rd_live  = mem_rd_i && (rd_i != '0);
   assign hit_rs1  = use_rs1_i && (rd_i == rs1_i);
   assign hit_rs2  = use_rs2_i && (rd_i == rs2_i);
   assign hazard_o = rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/ex_stall_ctrl.sv
// EX-stage stall/flush sequencer: load-use bubbles and shared mul/div start/wait/timeout/kill.
// Optional perf counters (ld_use_cnt, md_stall_cnt) are built when STALL_CNT_EN is defined.
module ex_stall_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned WIDTH_SOURCE = WIDTH_SOURCE_DEF,
   parameter int unsigned MD_TIMEOUT   = MD_TIMEOUT_DEF,
   parameter int unsigned CNT_W        = CNT_W_DEF
) (
   input  logic                    CLK,
   input  logic                    rst_n,
   input  logic                    ID_EX_Mem_Rd,
   input  logic [WIDTH_SOURCE-1:0] ID_EX_rd,
   input  logic [WIDTH_SOURCE-1:0] IF_ID_rs1,
   input  logic [WIDTH_SOURCE-1:0] IF_ID_rs2,
   input  logic                    IF_ID_use_rs1,
   input  logic                    IF_ID_use_rs2,
   input  logic                    md_req,
   input  logic                    md_done,
   input  logic                    br_flush,
   output logic                    PC_Stall,
   output logic                    IF_ID_Stall,
   output logic                    ID_EX_Flush,
   output logic                    EX_MEM_Stall,
   output logic                    md_start,
   output logic                    md_kill,
   output logic                    md_err,
   output logic                    md_busy
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]        ld_use_cnt,
   output logic [CNT_W-1:0]        md_stall_cnt
`endif
);

   localparam int unsigned TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

   md_state_t       state_q, state_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            hazard;
   logic            ld_use;
   logic            md_stall;
   logic            start_c;
   logic            kill_c;
   logic            err_c;

   ld_use_detect #(
      .W (WIDTH_SOURCE)
   ) u_ld_use_detect (
      .mem_rd_i  (ID_EX_Mem_Rd),
      .rd_i      (ID_EX_rd),
      .rs1_i     (IF_ID_rs1),
      .rs2_i     (IF_ID_rs2),
      .use_rs1_i (IF_ID_use_rs1),
      .use_rs2_i (IF_ID_use_rs2),
      .hazard_o  (hazard)
   );

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and mul/div handshakes; a branch flush overrides everything and drops stalls at once
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_stall = 1'b0;
      start_c  = 1'b0;
      kill_c   = 1'b0;
      err_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (md_req && !br_flush) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            cnt_d = '0;
            if (br_flush) begin
               kill_c  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               md_stall = 1'b1;
               start_c  = 1'b1;
               state_d  = md_done ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (br_flush) begin
               kill_c  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               md_stall = 1'b1;
               if (md_done) begin
                  state_d = ST_DONE;
               end else if (cnt_q == TW'(MD_TIMEOUT - 1)) begin
                  kill_c  = 1'b1;
                  err_c   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + TW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Load-use bubble only when idle and nothing of higher priority is acting this cycle
   assign ld_use = rst_n && (state_q == ST_IDLE) && hazard && !br_flush && !md_req;

   assign PC_Stall     = md_stall || ld_use;
   assign IF_ID_Stall  = md_stall || ld_use;
   assign ID_EX_Flush  = ld_use;
   assign EX_MEM_Stall = md_stall;
   assign md_start     = start_c;
   assign md_kill      = kill_c;
   assign md_err       = err_c;
   assign md_busy      = (state_q != ST_IDLE);

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] ld_use_cnt_q;
   logic [CNT_W-1:0] md_stall_cnt_q;
   logic             md_cycle;

   assign md_cycle = (state_q == ST_START) || (state_q == ST_WAIT);

   // Saturating perf counters
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         ld_use_cnt_q   <= '0;
         md_stall_cnt_q <= '0;
      end else begin
         if (ld_use && (ld_use_cnt_q != '1)) begin
            ld_use_cnt_q <= ld_use_cnt_q + CNT_W'(1);
         end
         if (md_cycle && (md_stall_cnt_q != '1)) begin
            md_stall_cnt_q <= md_stall_cnt_q + CNT_W'(1);
         end
      end
   end

   assign ld_use_cnt   = ld_use_cnt_q;
   assign md_stall_cnt = md_stall_cnt_q;
`else
   localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule
